// File: rtl/uni_shift_pkg.sv
// rtl/uni_shift_pkg.sv - op codes, FSM states and op classification for uni_shift_reg_seq
package uni_shift_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Ops that take the multi-cycle path; hold, load and reserved finish at accept.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ASR) ||
               (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// rtl/shift_step_unit.sv - combinational single-bit shift/rotate step
module shift_step_unit
    import uni_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] cur,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (op)
            OP_SHR:  nxt = {ser_in_msb, cur[WIDTH-1:1]};
            OP_SHL:  nxt = {cur[WIDTH-2:0], ser_in_lsb};
            OP_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            OP_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
            OP_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/uni_shift_reg_seq.sv
// rtl/uni_shift_reg_seq.sv - parametrised universal shift register, shift-by-N one bit per clock
module uni_shift_reg_seq
    import uni_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done
);

    logic [0:0]       state_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] count_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_nxt;
    logic             done_q;

    // Fill bits feed the step unit live so a serial stream is consumed one bit per step.
    shift_step_unit #(.WIDTH(WIDTH)) u_step (
        .op         (op_q),
        .cur        (data_q),
        .ser_in_msb (ser_in_msb),
        .ser_in_lsb (ser_in_lsb),
        .nxt        (step_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            count_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= sel;
                        if (sel == OP_LOAD) begin
                            data_q <= data_in;
                            done_q <= 1'b1;
                        end else if (is_shift_op(sel) && (amt != '0)) begin
                            state_q <= ST_SHIFT;
                            count_q <= amt;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    data_q  <= step_nxt;
                    count_q <= count_q - 1'b1;
                    if (count_q == AMT_W'(1)) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign ser_out_msb = data_q[WIDTH-1];
    assign ser_out_lsb = data_q[0];
    assign busy        = (state_q == ST_SHIFT);
    assign done        = done_q;

endmodule

// File: tb/tb_uni_shift_reg_seq.sv
// tb/tb_uni_shift_reg_seq.sv - directed self-checking bench for uni_shift_reg_seq
module tb_uni_shift_reg_seq;

    localparam logic [2:0] SEL_HOLD = 3'b000;
    localparam logic [2:0] SEL_SHR  = 3'b001;
    localparam logic [2:0] SEL_SHL  = 3'b010;
    localparam logic [2:0] SEL_LOAD = 3'b011;
    localparam logic [2:0] SEL_ASR  = 3'b100;
    localparam logic [2:0] SEL_ROR  = 3'b101;
    localparam logic [2:0] SEL_ROL  = 3'b110;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] sel;
    logic [3:0] amt;
    logic [7:0] data_in;
    logic       ser_in_msb;
    logic       ser_in_lsb;
    logic [7:0] data_out;
    logic       ser_out_msb;
    logic       ser_out_lsb;
    logic       busy;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    uni_shift_reg_seq #(.WIDTH(8), .AMT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sel         (sel),
        .amt         (amt),
        .data_in     (data_in),
        .ser_in_msb  (ser_in_msb),
        .ser_in_lsb  (ser_in_lsb),
        .data_out    (data_out),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] s, input logic [3:0] a, input logic [7:0] d);
        start = 1'b1; sel = s; amt = a; data_in = d;
        tick();
        start = 1'b0; sel = SEL_HOLD;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b1; sel = SEL_LOAD; data_in = 8'hFF;
        tick();
        tick();
        compared++;
        if (data_out !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", data_out); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
        compared++;
        if (ser_out_msb !== 1'b0 || ser_out_lsb !== 1'b0) begin
            mismatched++; $display("FAIL reset_ser_out got %b%b want 00", ser_out_msb, ser_out_lsb);
        end
        rst = 1'b1; start = 1'b0; sel = SEL_HOLD;
        tick();
    endtask

    task automatic test_rotate_right;
        logic [7:0] exp_v [0:2];
        exp_v = '{8'hD2, 8'h69, 8'hB4};
        do_op(SEL_LOAD, 4'd0, 8'hA5);
        compared++;
        if (data_out !== 8'hA5 || done !== 1'b1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL load_a5 got %h d%b b%b want a5 d1 b0", data_out, done, busy);
        end
        do_op(SEL_ROR, 4'd3, 8'h00);
        compared++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            mismatched++; $display("FAIL ror_accept got b%b d%b want b1 d0", busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (data_out !== exp_v[k] || busy !== (k < 2) || done !== (k == 2)) begin
                mismatched++;
                $display("FAIL ror_step%0d got %h b%b d%b want %h b%b d%b",
                         k + 1, data_out, busy, done, exp_v[k], k < 2, k == 2);
            end
        end
        tick();
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL ror_done_width got %b want 0", done); end
    endtask

    task automatic test_shift_left_fill;
        logic [7:0] exp_v [0:3];
        exp_v = '{8'h1F, 8'h3F, 8'h7F, 8'hFF};
        do_op(SEL_LOAD, 4'd0, 8'h0F);
        ser_in_lsb = 1'b1;
        do_op(SEL_SHL, 4'd4, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if (data_out !== exp_v[k] || done !== (k == 3)) begin
                mismatched++;
                $display("FAIL shl_step%0d got %h d%b want %h d%b", k + 1, data_out, done, exp_v[k], k == 3);
            end
        end
        ser_in_lsb = 1'b0;
    endtask

    task automatic test_asr_shr;
        do_op(SEL_LOAD, 4'd0, 8'h90);
        do_op(SEL_ASR, 4'd2, 8'h00);
        tick();
        tick();
        compared++;
        if (data_out !== 8'hE4 || done !== 1'b1) begin
            mismatched++; $display("FAIL asr2 got %h d%b want e4 d1", data_out, done);
        end
        ser_in_msb = 1'b0;
        do_op(SEL_SHR, 4'd1, 8'h00);
        tick();
        compared++;
        if (data_out !== 8'h72 || done !== 1'b1) begin
            mismatched++; $display("FAIL shr1 got %h d%b want 72 d1", data_out, done);
        end
    endtask

    task automatic test_start_while_busy;
        do_op(SEL_LOAD, 4'd0, 8'h3C);
        do_op(SEL_ROL, 4'd8, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) begin
                start = 1'b1; sel = SEL_LOAD; data_in = 8'h00; amt = 4'd1;
            end
            tick();
            start = 1'b0; sel = SEL_HOLD;
            if (k == 1) begin
                compared++;
                if (data_out !== 8'h78) begin mismatched++; $display("FAIL rol_step1 got %h want 78", data_out); end
            end
            if (k == 3) begin
                compared++;
                if (data_out !== 8'hE1 || busy !== 1'b1) begin
                    mismatched++; $display("FAIL rol_ignore_start got %h b%b want e1 b1", data_out, busy);
                end
            end
        end
        compared++;
        if (data_out !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL rol8 got %h d%b b%b want 3c d1 b0", data_out, done, busy);
        end
    endtask

    task automatic test_reset_mid_shift;
        do_op(SEL_LOAD, 4'd0, 8'hFF);
        ser_in_msb = 1'b0;
        do_op(SEL_SHR, 4'd5, 8'h00);
        tick();
        compared++;
        if (data_out !== 8'h7F) begin mismatched++; $display("FAIL shr_step1 got %h want 7f", data_out); end
        rst = 1'b0;
        tick();
        compared++;
        if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++; $display("FAIL mid_reset got %h b%b d%b want 00 b0 d0", data_out, busy, done);
        end
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            compared++;
            if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
                mismatched++;
                $display("FAIL post_reset_c%0d got %h b%b d%b want 00 b0 d0", k, data_out, busy, done);
            end
        end
    endtask

    task automatic test_amt_zero;
        do_op(SEL_LOAD, 4'd0, 8'h5A);
        do_op(SEL_SHR, 4'd0, 8'h00);
        compared++;
        if (done !== 1'b1 || busy !== 1'b0 || data_out !== 8'h5A) begin
            mismatched++; $display("FAIL amt0 got %h b%b d%b want 5a b0 d1", data_out, busy, done);
        end
        tick();
        compared++;
        if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h5A) begin
            mismatched++; $display("FAIL amt0_after got %h b%b d%b want 5a b0 d0", data_out, busy, done);
        end
    endtask

    task automatic test_back_to_back;
        do_op(SEL_LOAD, 4'd0, 8'h81);
        do_op(SEL_ROR, 4'd1, 8'h00);
        tick();
        compared++;
        if (data_out !== 8'hC0 || done !== 1'b1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL b2b_first got %h d%b b%b want c0 d1 b0", data_out, done, busy);
        end
        do_op(SEL_ROL, 4'd2, 8'h00);
        compared++;
        if (busy !== 1'b1 || done !== 1'b0 || data_out !== 8'hC0) begin
            mismatched++; $display("FAIL b2b_accept got %h b%b d%b want c0 b1 d0", data_out, busy, done);
        end
        tick();
        compared++;
        if (data_out !== 8'h81) begin mismatched++; $display("FAIL b2b_step1 got %h want 81", data_out); end
        tick();
        compared++;
        if (data_out !== 8'h03 || done !== 1'b1) begin
            mismatched++; $display("FAIL b2b_step2 got %h d%b want 03 d1", data_out, done);
        end
    endtask

    task automatic test_amt_over_width;
        int cycles;
        do_op(SEL_LOAD, 4'd0, 8'hFF);
        ser_in_lsb = 1'b0;
        do_op(SEL_SHL, 4'd9, 8'h00);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        compared++;
        if (cycles != 9) begin mismatched++; $display("FAIL shl9_latency got %0d want 9", cycles); end
        compared++;
        if (data_out !== 8'h00) begin mismatched++; $display("FAIL shl9_data got %h want 00", data_out); end
        do_op(SEL_LOAD, 4'd0, 8'h80);
        do_op(SEL_ASR, 4'd15, 8'h00);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        compared++;
        if (data_out !== 8'hFF || cycles != 15) begin
            mismatched++; $display("FAIL asr15 got %h after %0d want ff after 15", data_out, cycles);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; sel = SEL_HOLD; amt = 4'd0; data_in = 8'h00;
        ser_in_msb = 1'b0; ser_in_lsb = 1'b0;
        tick();
        test_reset();
        test_rotate_right();
        test_shift_left_fill();
        test_asr_shr();
        test_start_while_busy();
        test_reset_mid_shift();
        test_amt_zero();
        test_back_to_back();
        test_amt_over_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
